// File: rtl/upsample_pkg.sv
// upsample_pkg: shared FSM state type and counter-width helper for the nearest-neighbour upsampler
package upsample_pkg;
    typedef enum logic {FILL, EMIT} state_t;
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction
    localparam int DEF_COL_W = cnt_w(3);
    localparam int DEF_REP_W = cnt_w(3);
    localparam int DEF_ROW_W = cnt_w(3);
endpackage

// File: rtl/upsample_row_buffer.sv
// upsample_row_buffer: one input row of pixels, single write port, combinational read mux
module upsample_row_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 3,
    parameter int AW         = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end
    assign rdata = mem[raddr];
endmodule

// File: rtl/upsample_nn3x3.sv
// upsample_nn3x3: buffers one input row, then replays it as SCALE x SCALE blocks per pixel
module upsample_nn3x3
    import upsample_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int IN_WIDTH   = 3,
    parameter int IN_HEIGHT  = 3,
    parameter int SCALE      = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  valid_in,
    output logic                  ready_in,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  valid_out,
    input  logic                  ready_out,
    output logic                  frame_done
);
    localparam int CW = cnt_w(IN_WIDTH);
    localparam int SW = cnt_w(SCALE);
    localparam int HW = cnt_w(IN_HEIGHT);
    localparam logic [CW-1:0] COL_MAX = CW'(IN_WIDTH - 1);
    localparam logic [SW-1:0] REP_MAX = SW'(SCALE - 1);
    localparam logic [HW-1:0] ROW_MAX = HW'(IN_HEIGHT - 1);

    state_t                state;
    logic [CW-1:0]         wr_col, col;
    logic [SW-1:0]         rep_col, rep_row;
    logic [HW-1:0]         row;
    logic [DATA_WIDTH-1:0] rdata;

    assign ready_in  = (state == FILL);
    assign valid_out = (state == EMIT);
    // Forcing zero outside EMIT keeps o_data quiet while the buffer is being refilled
    assign o_data    = valid_out ? rdata : '0;

    upsample_row_buffer #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (IN_WIDTH),
        .AW        (CW)
    ) u_buf (
        .clk  (clk),
        .rst  (rst),
        .we   (ready_in && valid_in),
        .waddr(wr_col),
        .wdata(i_data),
        .raddr(col),
        .rdata(rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FILL;
            wr_col     <= '0;
            col        <= '0;
            rep_col    <= '0;
            rep_row    <= '0;
            row        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (state == FILL) begin
                if (valid_in) begin
                    if (wr_col == COL_MAX) begin
                        wr_col <= '0;
                        state  <= EMIT;
                    end else begin
                        wr_col <= wr_col + 1'b1;
                    end
                end
            end else if (ready_out) begin
                if (rep_col != REP_MAX) begin
                    rep_col <= rep_col + 1'b1;
                end else begin
                    rep_col <= '0;
                    if (col != COL_MAX) begin
                        col <= col + 1'b1;
                    end else begin
                        col <= '0;
                        if (rep_row != REP_MAX) begin
                            rep_row <= rep_row + 1'b1;
                        end else begin
                            rep_row <= '0;
                            state   <= FILL;
                            if (row == ROW_MAX) begin
                                row        <= '0;
                                frame_done <= 1'b1;
                            end else begin
                                row <= row + 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_upsample_nn3x3.sv
// tb_upsample_nn3x3: directed checks of the 3x3 upsampler plus a SCALE=1 degenerate instance
module tb_upsample_nn3x3;
    logic        clk = 0;
    logic        rst = 1;
    logic [31:0] i_data = 0;
    logic        valid_in = 0;
    logic        ready_in;
    logic [31:0] o_data;
    logic        valid_out;
    logic        ready_out = 0;
    logic        frame_done;
    logic [31:0] i_data1 = 0;
    logic        valid_in1 = 0;
    logic        ready_in1;
    logic [31:0] o_data1;
    logic        valid_out1;
    logic        ready_out1 = 0;
    logic        frame_done1;
    int          checks = 0;
    int          errors = 0;
    int          fd_cnt = 0;

    always #5 clk = ~clk;

    upsample_nn3x3 u0 (
        .clk(clk), .rst(rst), .i_data(i_data), .valid_in(valid_in), .ready_in(ready_in),
        .o_data(o_data), .valid_out(valid_out), .ready_out(ready_out), .frame_done(frame_done)
    );

    upsample_nn3x3 #(.DATA_WIDTH(32), .IN_WIDTH(4), .IN_HEIGHT(2), .SCALE(1)) u1 (
        .clk(clk), .rst(rst), .i_data(i_data1), .valid_in(valid_in1), .ready_in(ready_in1),
        .o_data(o_data1), .valid_out(valid_out1), .ready_out(ready_out1), .frame_done(frame_done1)
    );

    always begin
        @(posedge clk);
        #1;
        if (frame_done) fd_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_row(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        logic [31:0] px [3];
        int g;
        px = '{a, b, c};
        for (int i = 0; i < 3; i++) begin
            valid_in = 1;
            i_data   = px[i];
            g = 0;
            while (!ready_in && g < 200) begin
                step();
                g++;
            end
            check("send_timeout", 32'(g < 200), 1);
            step();
        end
        valid_in = 0;
    endtask

    // Pulls 27 beats of one row group; optional random backpressure and held-high valid_in
    task automatic emit_row(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                            input bit rnd, input bit hold_in, input bit last, input int n_beats);
        logic [31:0] px [3];
        logic [31:0] prev;
        bit          stalled;
        int          beats, guard, low_in;
        px = '{a, b, c};
        beats = 0; guard = 0; low_in = 0; stalled = 0; prev = 0;
        check("latency_valid", 32'(valid_out), 1);
        if (hold_in) begin
            valid_in = 1;
            i_data   = 32'hdead_beef;
        end
        while (beats < n_beats && guard < 1000) begin
            ready_out = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!ready_in) low_in++;
            if (hold_in) check("rdy_in_emit", 32'(ready_in), 0);
            if (valid_out && ready_out) begin
                check("pix", o_data, px[(beats % 9) / 3]);
                beats++;
            end else if (valid_out) begin
                prev    = o_data;
                stalled = 1;
            end
            step();
            guard++;
            if (stalled) begin
                check("stall_hold", o_data, prev);
                stalled = 0;
            end
        end
        check("emit_timeout", 32'(guard < 1000), 1);
        valid_in  = 0;
        ready_out = 0;
        if (n_beats == 27) begin
            check("frame_done", 32'(frame_done), 32'(last));
            check("back_to_fill", 32'(ready_in), 1);
            if (!rnd) check("rdy_in_low_cnt", 32'(low_in), 27);
        end
    endtask

    task automatic run_frame(input int base, input bit rnd, input bit hold_in);
        for (int r = 0; r < 3; r++) begin
            send_row(base + 3 * r + 1, base + 3 * r + 2, base + 3 * r + 3);
            emit_row(base + 3 * r + 1, base + 3 * r + 2, base + 3 * r + 3, rnd, hold_in, r == 2, 27);
        end
    endtask

    task automatic do_reset();
        rst = 1;
        #1;
        check("rst_valid_out", 32'(valid_out), 0);
        check("rst_o_data", o_data, 0);
        step();
        step();
        rst = 0;
        step();
        check("rel_ready_in", 32'(ready_in), 1);
        check("rel_valid_out", 32'(valid_out), 0);
        check("rel_frame_done", 32'(frame_done), 0);
        check("rel_o_data", o_data, 0);
    endtask

    initial begin
        do_reset();
        // 1: plain frame
        fd_cnt = 0;
        run_frame(0, 0, 0);
        step();
        check("t1_fd_pulses", 32'(fd_cnt), 1);
        // 2: random backpressure
        fd_cnt = 0;
        run_frame(0, 1, 0);
        step();
        check("t2_fd_pulses", 32'(fd_cnt), 1);
        // 3: valid_in held high during EMIT
        run_frame(0, 0, 1);
        // 4: reset on beat 13
        send_row(5, 6, 7);
        emit_row(5, 6, 7, 0, 0, 0, 12);
        do_reset();
        send_row(10, 20, 30);
        emit_row(10, 20, 30, 0, 0, 0, 27);
        do_reset();
        // 6: two back-to-back frames
        fd_cnt = 0;
        run_frame(10, 0, 0);
        run_frame(20, 0, 0);
        step();
        check("t6_fd_pulses", 32'(fd_cnt), 2);
        // 5: SCALE=1 instance
        begin
            int k, g;
            for (int r = 0; r < 2; r++) begin
                for (int i = 0; i < 4; i++) begin
                    check("s1_ready_in", 32'(ready_in1), 1);
                    valid_in1 = 1;
                    i_data1   = 32'(4 * r + i + 1);
                    step();
                end
                valid_in1  = 0;
                ready_out1 = 1;
                k = 0; g = 0;
                while (k < 4 && g < 100) begin
                    if (valid_out1) begin
                        check("s1_pix", o_data1, 32'(4 * r + k + 1));
                        k++;
                    end
                    step();
                    g++;
                end
                check("s1_timeout", 32'(g < 100), 1);
                check("s1_frame_done", 32'(frame_done1), 32'(r == 1));
                ready_out1 = 0;
            end
            step();
            check("s1_fd_clear", 32'(frame_done1), 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
